// File: rtl/clm_pkg.sv
// Shared types and constants for the CLM randomness feeder.
package clm_pkg;

    typedef logic [4:0] p_det_t;
    typedef logic [7:0] red_poly_t;

    localparam int          NUM_RAND      = 23;
    localparam logic [31:0] CLM_LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL_P,
        ST_FILL_V,
        ST_ISSUE,
        ST_WAIT
    } clm_state_t;

endpackage

// File: rtl/clm_lfsr8.sv
// Combinational eight-step advance of the 32-bit Galois LFSR.
// Each step shifts right; when the bit shifted out is 1 the polynomial is XORed in.
module clm_lfsr8
    import clm_pkg::*;
(
    input  logic [31:0] lfsr_i,
    output logic [31:0] lfsr_o
);

    logic [31:0] step_s;

    // Unrolled eight Galois steps
    always_comb begin
        step_s = lfsr_i;
        for (int i = 0; i < 8; i++) begin
            if (step_s[0]) begin
                step_s = {1'b0, step_s[31:1]} ^ CLM_LFSR_POLY;
            end else begin
                step_s = {1'b0, step_s[31:1]};
            end
        end
        lfsr_o = step_s;
    end

endmodule

// File: rtl/clm_rand_feeder.sv
// Upstream feeder for the CLM AES core: latches a host request, draws one
// p_det plus 23 nonzero mask bytes, issues the request and holds it until done.
// Build option: CLM_RAND_FIXED_EN replaces the LFSR with fixed candidates
// (p_det = 11, mask bytes = 109) and ignores seed/seed_vld.
module clm_rand_feeder
    import clm_pkg::*;
#(
    parameter int          NUM_P = 30,
    parameter logic [31:0] SEED  = 32'hACE1_2468
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          seed_vld,
    input  logic [31:0]                   seed,
    input  logic                          drdy_i,
    input  logic [127:0]                  plaintext,
    input  logic [127:0]                  key,
    output logic                          busy,
    output logic                          drop,
    output logic                          core_drdy,
    output logic [127:0]                  core_plaintext,
    output logic [127:0]                  core_key,
    output p_det_t                        p_det,
    output red_poly_t [0:NUM_RAND-1]      random_vect,
    input  logic                          core_done
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_RAND - 1);

    clm_state_t                state_q, state_d;
    logic [4:0]                idx_q, idx_d;
    p_det_t                    p_det_q, p_det_d;
    red_poly_t [0:NUM_RAND-1]  vect_q, vect_d;
    logic [127:0]              pt_q, pt_d;
    logic [127:0]              key_q, key_d;
    logic                      drop_q, drop_d;

    p_det_t                    cand_p;
    red_poly_t                 cand_v;
    logic                      p_ok;

`ifdef CLM_RAND_FIXED_EN
    logic unused_seed;
    assign unused_seed = ^{seed_vld, seed};
    assign cand_p      = 5'd11;
    assign cand_v      = 8'd109;
    assign p_ok        = 1'b1;
`else
    localparam logic [5:0] NUM_P_W = 6'(NUM_P);

    logic [31:0] lfsr_q, lfsr_d, lfsr_adv;

    clm_lfsr8 u_lfsr8 (
        .lfsr_i (lfsr_q),
        .lfsr_o (lfsr_adv)
    );

    // Candidates come from the register value before this cycle's advance
    assign cand_p = lfsr_q[4:0];
    assign cand_v = lfsr_q[7:0];
    assign p_ok   = ({1'b0, cand_p} < NUM_P_W);

    // LFSR only moves while filling; seeds are accepted only in IDLE
    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == ST_IDLE) begin
            if (seed_vld) begin
                lfsr_d = (seed == 32'd0) ? SEED : seed;
            end
        end else if (state_q == ST_FILL_P || state_q == ST_FILL_V) begin
            lfsr_d = lfsr_adv;
        end
    end

    // LFSR register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Next-state and datapath updates for the request sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        p_det_d = p_det_q;
        vect_d  = vect_q;
        pt_d    = pt_q;
        key_d   = key_q;
        drop_d  = drdy_i && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (drdy_i) begin
                    pt_d    = plaintext;
                    key_d   = key;
                    idx_d   = 5'd0;
                    state_d = ST_FILL_P;
                end
            end
            ST_FILL_P: begin
                if (p_ok) begin
                    p_det_d = cand_p;
                    state_d = ST_FILL_V;
                end
            end
            ST_FILL_V: begin
                if (cand_v != 8'd0) begin
                    vect_d[idx_q] = cand_v;
                    idx_d         = idx_q + 5'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and request registers; reset abandons any request in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            p_det_q <= '0;
            vect_q  <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            p_det_q <= p_det_d;
            vect_q  <= vect_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            drop_q  <= drop_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign core_drdy      = (state_q == ST_ISSUE);
    assign drop           = drop_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign p_det          = p_det_q;
    assign random_vect    = vect_q;

endmodule

// File: doc/clm_rand_feeder.md
# clm_rand_feeder

Upstream feeder for the CLM AES core. It accepts a host encryption request (plaintext, key, data-ready), draws a fresh randomness set from an internal LFSR, and issues the request to the core. The randomness set is one `p_det` from the limited polynomial set plus 23 nonzero `red_poly_t` mask bytes. It holds all core inputs stable until the core reports completion, and drops host requests that arrive while busy.

## Interface
- `NUM_P`, default 30: number of legal `p_det` values; legal range is 0..NUM_P-1, with NUM_P ≤ 32.
- `SEED`, default 32'hACE1_2468: LFSR reset value, also substituted for a zero seed.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `seed_vld`  in  1  load `seed` into the LFSR; honoured only in IDLE.
- `seed`  in  32  LFSR seed.
- `drdy_i`  in  1  host request strobe; sampled only in IDLE.
- `plaintext`  in  128  host plaintext.
- `key`  in  128  host key.
- `busy`  out  1  high in every state except IDLE.
- `drop`  out  1  one-cycle pulse when `drdy_i`=1 outside IDLE.
- `core_drdy`  out  1  one-cycle request pulse to the core.
- `core_plaintext`  out  128  latched plaintext.
- `core_key`  out  128  latched key.
- `p_det`  out  `p_det_t` (5)  selected polynomial index.
- `random_vect`  out  `red_poly_t [0:22]`  mask bytes.
- `core_done`  in  1  the core's `drdy_o`.

## Operation
- The FSM has five states: IDLE, FILL_P, FILL_V, ISSUE, WAIT.
- **IDLE:**
  - If `seed_vld`=1, the LFSR loads `seed`, or `SEED` when `seed`=0.
  - If `drdy_i`=1, `plaintext` and `key` are latched, `idx`←0, and the FSM goes to FILL_P.
  - If both arrive in the same cycle, both actions happen.
- **LFSR:**
  - 32-bit Galois, polynomial 32'h8020_0003.
  - Advances 8 steps per cycle, and only in FILL_P and FILL_V.
  - The candidate value is the current register, before the advance.
- **FILL_P:** candidate is `c = lfsr[4:0]`.
  - If c < NUM_P: `p_det`←c and go to FILL_V.
  - Otherwise reject `c` and stay in FILL_P.
- **FILL_V:** candidate is `b = lfsr[7:0]`.
  - If b ≠ 0: `random_vect[idx]`←b and `idx`++.
  - If b = 0: reject it; `idx` is unchanged.
  - Go to ISSUE after the write to `idx`=22.
- **ISSUE:** `core_drdy`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** go to IDLE when `core_done`=1. A new request is accepted on the following cycle at the earliest.
- `core_done` is ignored outside WAIT.
- `seed_vld` is ignored outside IDLE.
- `drdy_i` outside IDLE produces a `drop` pulse and has no other effect.
- `core_plaintext`, `core_key`, `p_det` and `random_vect` are stable from the `core_drdy` cycle until WAIT exits.

## Timing
- Reset values: `busy`, `drop`, `core_drdy`, `core_plaintext`, `core_key`, `p_det` and every `random_vect` entry are 0. State is IDLE, `idx`=0, LFSR=`SEED`.
- Reset takes priority over every other input.
- Reset mid-operation abandons the request. No `core_drdy` is issued, and outputs return to their reset values the following cycle.
- Latency with no rejections: `drdy_i` is sampled in cycle 0, FILL_P occupies cycle 1, FILL_V occupies cycles 2–24, and `core_drdy` is high in cycle 25.
- Each rejection adds exactly one cycle.
- `drop` is asserted in the cycle after the ignored `drdy_i`.
- `busy` rises the cycle after acceptance and falls the cycle after `core_done`.

## Configuration
- `CLM_RAND_FIXED_EN` defined:
  - The LFSR is not instantiated and `seed`/`seed_vld` are ignored.
  - FILL_P always writes 5'd11. FILL_V always writes 8'd109, so there are no rejections.
  - Latency is exactly 25 cycles; FSM and handshake are unchanged.
- Undefined: LFSR-driven behaviour as described under Operation.

## Structure
- Shared package `clm_pkg` holds:
  - `p_det_t` (5-bit), `red_poly_t` (8-bit);
  - `NUM_RAND`=23;
  - `CLM_LFSR_POLY`=32'h8020_0003;
  - the FSM state enum.
- One sub-module, `clm_lfsr8`, performs the combinational 8-step Galois advance (32 bits in, 32 bits out).
- All registers live in `clm_rand_feeder`.

## Test plan
- **Fixed mode:** with `CLM_RAND_FIXED_EN`, reset, then `drdy_i`=1 for one cycle with `plaintext`=128'hff, `key`=0.
  - `core_drdy` pulses in cycle 25 and `busy`=1 throughout.
  - `core_plaintext`=128'hff, `p_det`=5'd11, all 23 `random_vect` entries are 8'd109.
  - `core_done` → `busy` low the next cycle.
- **Zero seed:** `seed_vld`=1 with `seed`=0 in IDLE → LFSR equals 32'hACE1_2468.
  - A following request produces `p_det` and `random_vect` identical to a bench reference model.
  - `p_det` < 30, no zero byte, and `core_drdy` arrives exactly at 25 + rejection count cycles.
- **Rejection:** LFSR mode, NUM_P=1, seed 32'h0000_0001 → FILL_P repeats until `lfsr[4:0]`=0. `p_det`=0, and latency matches the model including rejections.
- **Dropped request:** `drdy_i`=1 with `plaintext`=128'h1 during WAIT → one-cycle `drop` pulse; `core_plaintext` stays 128'hff; no second `core_drdy`.
- **Reset mid-fill:** `rst_n`=0 in the 10th FILL_V cycle → next cycle all outputs are 0 and state is IDLE; `core_drdy` never pulses.
- **Ignored strobes:** `core_done`=1 in IDLE and in FILL_V, and `seed_vld`=1 in FILL_V → no state change, latency unaffected, LFSR not reloaded.
